obb_sat_tester: RTL and testbench



---
 rtl/obb_sat_tester_pkg.sv | 31 +++
 rtl/obb_sat_tester_sat_dot.sv | 17 +
 rtl/obb_sat_tester.sv | 141 ++++++++++++++
 tb/tb_obb_sat_tester.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/obb_sat_tester_pkg.sv
// Shared types and widths for the OBB separating-axis tester and its dot-product unit.
package obb_sat_tester_pkg;

    localparam int unsigned POS_W    = 16;
    localparam int unsigned POS_FRAC = 6;
    localparam int unsigned AX_W     = 9;
    localparam int unsigned AX_FRAC  = 7;
    localparam int unsigned PROD_W   = POS_W + AX_W;
    localparam int unsigned PROJ_W   = PROD_W + 1;

    // Field order puts x in the LSBs so a packed {y,x} bus maps directly.
    typedef struct packed {
        logic signed [POS_W-1:0] y;
        logic signed [POS_W-1:0] x;
    } pt_t;

    typedef struct packed {
        logic signed [AX_W-1:0] y;
        logic signed [AX_W-1:0] x;
    } axis_t;

    typedef logic signed [PROJ_W-1:0] proj_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROJ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } sat_state_t;

endpackage

// File: rtl/obb_sat_tester_sat_dot.sv
// Combinational full-precision projection of a point onto an axis.
module sat_dot
    import obb_sat_tester_pkg::*;
(
    input  pt_t   pt_i,
    input  axis_t ax_i,
    output proj_t proj_c
);

    logic signed [PROD_W-1:0] prod_x;
    logic signed [PROD_W-1:0] prod_y;

    assign prod_x = PROD_W'($signed(pt_i.x)) * PROD_W'($signed(ax_i.x));
    assign prod_y = PROD_W'($signed(pt_i.y)) * PROD_W'($signed(ax_i.y));
    assign proj_c = PROJ_W'(prod_x) + PROJ_W'(prod_y);

endmodule

// File: rtl/obb_sat_tester.sv
// Separating-axis overlap test of two OBBs, one shared dot-product unit, early exit.
module obb_sat_tester
    import obb_sat_tester_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [8*POS_W-1:0]  a_pts,
    input  logic [8*POS_W-1:0]  b_pts,
    input  logic [2*AX_W-1:0]   a_u,
    input  logic [2*AX_W-1:0]   a_v,
    input  logic [2*AX_W-1:0]   b_u,
    input  logic [2*AX_W-1:0]   b_v,
    output logic                busy,
    output logic                done,
    output logic                collide,
    output logic [1:0]          sep_axis
);

    sat_state_t state_q, state_d;
    pt_t [7:0]  pts_q, pts_d;
    axis_t [3:0] axes_q, axes_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] axis_q, axis_d;
    proj_t      min_a_q, min_a_d, max_a_q, max_a_d;
    proj_t      min_b_q, min_b_d, max_b_q, max_b_d;
    logic       busy_q, busy_d, done_q, done_d, collide_q, collide_d;
    logic [1:0] sep_axis_q, sep_axis_d;

    proj_t proj_c;
    logic  sep_c;

    // Points 0..3 belong to box A, 4..7 to box B; axes A.u, A.v, B.u, B.v.
    sat_dot u_dot (
        .pt_i   (pts_q[idx_q]),
        .ax_i   (axes_q[axis_q]),
        .proj_c (proj_c)
    );

    assign sep_c = (max_a_q < min_b_q) || (max_b_q < min_a_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pts_q      <= '0;
            axes_q     <= '0;
            idx_q      <= '0;
            axis_q     <= '0;
            min_a_q    <= '0;
            max_a_q    <= '0;
            min_b_q    <= '0;
            max_b_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            collide_q  <= 1'b0;
            sep_axis_q <= '0;
        end else begin
            state_q    <= state_d;
            pts_q      <= pts_d;
            axes_q     <= axes_d;
            idx_q      <= idx_d;
            axis_q     <= axis_d;
            min_a_q    <= min_a_d;
            max_a_q    <= max_a_d;
            min_b_q    <= min_b_d;
            max_b_q    <= max_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            collide_q  <= collide_d;
            sep_axis_q <= sep_axis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pts_d      = pts_q;
        axes_d     = axes_q;
        idx_d      = idx_q;
        axis_d     = axis_q;
        min_a_d    = min_a_q;
        max_a_d    = max_a_q;
        min_b_d    = min_b_q;
        max_b_d    = max_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        collide_d  = collide_q;
        sep_axis_d = sep_axis_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pts_d   = {b_pts, a_pts};
                    axes_d  = {b_v, b_u, a_v, a_u};
                    idx_d   = '0;
                    axis_d  = '0;
                    busy_d  = 1'b1;
                    state_d = PROJ;
                end
            end
            PROJ: begin
                // First point of each box seeds its interval.
                if (idx_q[2]) begin
                    if (idx_q[1:0] == 2'd0 || proj_c < min_b_q) min_b_d = proj_c;
                    if (idx_q[1:0] == 2'd0 || proj_c > max_b_q) max_b_d = proj_c;
                end else begin
                    if (idx_q[1:0] == 2'd0 || proj_c < min_a_q) min_a_d = proj_c;
                    if (idx_q[1:0] == 2'd0 || proj_c > max_a_q) max_a_d = proj_c;
                end
                idx_d = 3'(idx_q + 3'd1);
                if (idx_q == 3'd7) state_d = CMP;
            end
            CMP: begin
                if (sep_c) begin
                    collide_d  = 1'b0;
                    sep_axis_d = axis_q;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else if (axis_q == 2'd3) begin
                    collide_d  = 1'b1;
                    sep_axis_d = '0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    axis_d  = 2'(axis_q + 2'd1);
                    state_d = PROJ;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign collide  = collide_q;
    assign sep_axis = sep_axis_q;

endmodule

// File: tb/tb_obb_sat_tester.sv
// Directed-vector bench for obb_sat_tester: latency, result, restart and reset behaviour.
module tb_obb_sat_tester;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start;
    logic [127:0] a_pts, b_pts;
    logic [17:0]  a_u, a_v, b_u, b_v;
    logic         busy, done, collide;
    logic [1:0]   sep_axis;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    obb_sat_tester dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .a_pts    (a_pts),
        .b_pts    (b_pts),
        .a_u      (a_u),
        .a_v      (a_v),
        .b_u      (b_u),
        .b_v      (b_v),
        .busy     (busy),
        .done     (done),
        .collide  (collide),
        .sep_axis (sep_axis)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] mkpt(input int x, input int y);
        return {16'(y), 16'(x)};
    endfunction

    function automatic logic [17:0] mkax(input int x, input int y);
        return {9'(y), 9'(x)};
    endfunction

    // Axis-aligned box in raw Q10.6 units, corners counter-clockwise from (-,-).
    function automatic logic [127:0] box(input int cx, input int cy, input int hx, input int hy);
        return {mkpt(cx - hx, cy + hy), mkpt(cx + hx, cy + hy),
                mkpt(cx + hx, cy - hy), mkpt(cx - hx, cy - hy)};
    endfunction

    task automatic set_inputs(input logic [127:0] a, input logic [127:0] b,
                              input logic [17:0] au, input logic [17:0] av,
                              input logic [17:0] bu, input logic [17:0] bv);
        a_pts = a; b_pts = b; a_u = au; a_v = av; b_u = bu; b_v = bv;
    endtask

    task automatic scramble_inputs();
        a_pts = {4{32'h1234_8001}};
        b_pts = {4{32'h7FFF_8000}};
        a_u = 18'h3_0101; a_v = 18'h0_00FF; b_u = 18'h2_AAAA; b_v = 18'h1_5555;
    endtask

    // Starts a test (start edge ends cycle 0), optionally pulses start again at pulse_cyc.
    task automatic run(input string tag, input int exp_lat, input int exp_col,
                       input int exp_sep, input int pulse_cyc);
        int cyc;
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        cyc = 1;
        check({tag, "_busy1"}, int'(busy), 1);
        while (!done && cyc < 60) begin
            @(posedge Clk);
            #1;
            cyc++;
            start = (cyc == pulse_cyc);
        end
        start = 1'b0;
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_collide"}, int'(collide), exp_col);
        check({tag, "_sep"}, int'(sep_axis), exp_sep);
        check({tag, "_busy_done"}, int'(busy), 1);
        @(posedge Clk);
        #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_busy_idle"}, int'(busy), 0);
        check({tag, "_collide_hold"}, int'(collide), exp_col);
    endtask

    task automatic count_dones(input int n_cyc, output int n);
        n = 0;
        for (int i = 0; i < n_cyc; i++) begin
            @(posedge Clk);
            #1;
            if (done) n++;
        end
    endtask

    logic [17:0] ux, uy;
    logic [127:0] a_box;
    int nd, first_done, second_done;

    initial begin
        ux = mkax(128, 0);
        uy = mkax(0, 128);
        a_box = box(0, 0, 128, 128);
        start = 1'b0;
        Reset = 1'b1;
        set_inputs(a_box, box(640, 0, 128, 128), ux, uy, ux, uy);
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_collide", int'(collide), 0);
        check("rst_sep", int'(sep_axis), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Separated along A.u; a stray start at cycle 5 must be ignored.
        set_inputs(a_box, box(640, 0, 128, 128), ux, uy, ux, uy);
        run("sep_x", 10, 0, 0, 5);
        count_dones(40, nd);
        check("no_extra_done", nd, 0);

        set_inputs(a_box, box(192, 0, 128, 128), ux, uy, ux, uy);
        run("overlap", 37, 1, 0, 0);

        set_inputs(a_box, box(256, 0, 128, 128), ux, uy, ux, uy);
        run("touch", 37, 1, 0, 0);

        set_inputs(a_box, box(0, 640, 128, 128), ux, uy, ux, uy);
        run("sep_y", 19, 0, 1, 0);

        // 45-degree box A against axis-aligned B at x 3.5..5.5, y -1..1.
        set_inputs({mkpt(0, -181), mkpt(-181, 0), mkpt(0, 181), mkpt(181, 0)},
                   box(288, 0, 64, 64), mkax(91, 91), mkax(-91, 91), ux, uy);
        run("rot45", 28, 0, 2, 0);

        // Reset in cycle 15 of a colliding test: outputs clear at once, no done follows.
        set_inputs(a_box, box(192, 0, 128, 128), ux, uy, ux, uy);
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_collide", int'(collide), 0);
        check("midrst_sep", int'(sep_axis), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        count_dones(45, nd);
        check("midrst_no_done", nd, 0);

        set_inputs(a_box, box(192, 0, 128, 128), ux, uy, ux, uy);
        run("after_rst", 37, 1, 0, 0);

        // start held high: second acceptance in the IDLE cycle after DONE.
        set_inputs(a_box, box(640, 0, 128, 128), ux, uy, ux, uy);
        @(negedge Clk);
        start = 1'b1;
        first_done = 0;
        second_done = 0;
        for (int c = 1; c <= 30 && second_done == 0; c++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                if (first_done == 0) first_done = c;
                else begin
                    second_done = c;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first", first_done, 10);
        check("b2b_second", second_done, 21);
        check("b2b_collide", int'(collide), 0);
        repeat (3) @(posedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
